// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select encodings, NZCV bit positions and the packed flag type.
package alu_pkg;

    typedef enum logic [2:0] {
        SEL_XNOR   = 3'd0,
        SEL_XOR    = 3'd1,
        SEL_OR     = 3'd2,
        SEL_AND    = 3'd3,
        SEL_ADDSUB = 3'd4
    } alu_sel_e;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Valid/ready bundle between an ALU, its result stage and the downstream consumer.
interface alu_result_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [2:0]       in_sel;
    logic             in_cout;
    logic             in_cmsb;
    logic             in_setf;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_nzcv;
    logic [3:0]       flags;

    modport master (
        output in_valid, in_result, in_sel, in_cout, in_cmsb, in_setf, out_ready,
        input  in_ready, out_valid, out_result, out_nzcv, flags
    );

    modport slave (
        input  in_valid, in_result, in_sel, in_cout, in_cmsb, in_setf, out_ready,
        output in_ready, out_valid, out_result, out_nzcv, flags
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generator for an ALU result word; carry/overflow only meaningful for ADD/SUB.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] result_i,
    input  logic [2:0]       sel_i,
    input  logic             cout_i,
    input  logic             cmsb_i,
    output nzcv_t            nzcv_o
);

    always_comb begin
        nzcv_o   = '0;
        nzcv_o.n = result_i[WIDTH-1];
        nzcv_o.z = (result_i == '0);
        if (sel_i == 3'(SEL_ADDSUB)) begin
            nzcv_o.c = cout_i;
            nzcv_o.v = cout_i ^ cmsb_i;
        end
    end

endmodule

// File: rtl/alu_result_stage_core.sv
// One-cycle valid/ready result buffer with per-beat NZCV and sticky flags.
// Define ALU_RESULT_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module alu_result_stage_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input logic               clk,
    input logic               reset,
    alu_result_stage_if.slave bus
);

    nzcv_t            beat_nzcv;
    logic             in_fire;
    logic             out_fire;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_result_q, main_result_d;
    logic [3:0]       main_nzcv_q, main_nzcv_d;
    logic             main_setf_q, main_setf_d;
    logic [3:0]       flags_q, flags_d;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result_i (bus.in_result),
        .sel_i    (bus.in_sel),
        .cout_i   (bus.in_cout),
        .cmsb_i   (bus.in_cmsb),
        .nzcv_o   (beat_nzcv)
    );

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = main_valid_q && bus.out_ready;

`ifdef ALU_RESULT_STAGE_SKID_EN
    logic             skid_empty_q, skid_empty_d;
    logic [WIDTH-1:0] skid_result_q, skid_result_d;
    logic [3:0]       skid_nzcv_q, skid_nzcv_d;
    logic             skid_setf_q, skid_setf_d;

    // in_ready comes straight from a flop, so out_ready never reaches the upstream path.
    assign bus.in_ready = skid_empty_q;
`else
    assign bus.in_ready = !main_valid_q || bus.out_ready;
`endif

    always_comb begin
        main_valid_d  = main_valid_q;
        main_result_d = main_result_q;
        main_nzcv_d   = main_nzcv_q;
        main_setf_d   = main_setf_q;
        flags_d       = flags_q;
        if (out_fire && main_setf_q) begin
            flags_d = main_nzcv_q;
        end
`ifdef ALU_RESULT_STAGE_SKID_EN
        skid_empty_d  = skid_empty_q;
        skid_result_d = skid_result_q;
        skid_nzcv_d   = skid_nzcv_q;
        skid_setf_d   = skid_setf_q;
        if (!skid_empty_q) begin
            if (out_fire) begin
                main_result_d = skid_result_q;
                main_nzcv_d   = skid_nzcv_q;
                main_setf_d   = skid_setf_q;
                skid_empty_d  = 1'b1;
            end
        end else if (in_fire) begin
            if (!main_valid_q || out_fire) begin
                main_valid_d  = 1'b1;
                main_result_d = bus.in_result;
                main_nzcv_d   = beat_nzcv;
                main_setf_d   = bus.in_setf;
            end else begin
                skid_empty_d  = 1'b0;
                skid_result_d = bus.in_result;
                skid_nzcv_d   = beat_nzcv;
                skid_setf_d   = bus.in_setf;
            end
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end
`else
        if (in_fire) begin
            main_valid_d  = 1'b1;
            main_result_d = bus.in_result;
            main_nzcv_d   = beat_nzcv;
            main_setf_d   = bus.in_setf;
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q  <= 1'b0;
            main_result_q <= '0;
            main_nzcv_q   <= '0;
            main_setf_q   <= 1'b0;
            flags_q       <= '0;
`ifdef ALU_RESULT_STAGE_SKID_EN
            skid_empty_q  <= 1'b1;
            skid_result_q <= '0;
            skid_nzcv_q   <= '0;
            skid_setf_q   <= 1'b0;
`endif
        end else begin
            main_valid_q  <= main_valid_d;
            main_result_q <= main_result_d;
            main_nzcv_q   <= main_nzcv_d;
            main_setf_q   <= main_setf_d;
            flags_q       <= flags_d;
`ifdef ALU_RESULT_STAGE_SKID_EN
            skid_empty_q  <= skid_empty_d;
            skid_result_q <= skid_result_d;
            skid_nzcv_q   <= skid_nzcv_d;
            skid_setf_q   <= skid_setf_d;
`endif
        end
    end

    assign bus.out_valid  = main_valid_q;
    assign bus.out_result = main_result_q;
    assign bus.out_nzcv   = main_nzcv_q;
    assign bus.flags      = flags_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage top: flat ports bundled into the stage interface for the core.
// Build option: ALU_RESULT_STAGE_SKID_EN selects the two-entry skid buffer.
module alu_result_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_sel,
    input  logic             in_cout,
    input  logic             in_cmsb,
    input  logic             in_setf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_nzcv,
    output logic [3:0]       flags
);

    alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.in_result = in_result;
    assign bus.in_sel    = in_sel;
    assign bus.in_cout   = in_cout;
    assign bus.in_cmsb   = in_cmsb;
    assign bus.in_setf   = in_setf;
    assign bus.out_ready = out_ready;

    assign in_ready   = bus.in_ready;
    assign out_valid  = bus.out_valid;
    assign out_result = bus.out_result;
    assign out_nzcv   = bus.out_nzcv;
    assign flags      = bus.flags;

    alu_result_stage_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

endmodule
